// File: rtl/demux_rr_dispatcher_pkg.sv
// Shared types and helpers for the demux dispatcher.
// Channel count, select width, control bundle.
package demux_pkg;

  localparam int N_CH = 4;
  localparam int CH_W = 2;

  typedef struct packed {
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] sel;
    logic            grant;
    logic [7:0]      cnt;
  } ctl_t;

  function automatic logic [CH_W-1:0] rr_next(
    input logic [CH_W-1:0] idx
  );
    return idx + CH_W'(1);
  endfunction

  function automatic int ch_slice(
    input int idx,
    input int w
  );
    return idx * w;
  endfunction

endpackage

// File: rtl/demux_rr_dispatcher_if.sv
// Handshake bundle between the input stream,
// the dispatcher and the four channel consumers.
interface demux_rr_dispatcher_if #(
  parameter int DATA_W = 1
);
  import demux_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic [N_CH-1:0]          en_mask;
  logic [N_CH-1:0]          out_valid;
  logic [N_CH-1:0]          out_ready;
  logic [N_CH*DATA_W-1:0]   out_data;
  logic [CH_W-1:0]          sel;
  logic                     grant;
  logic [7:0]               disp_cnt;

  modport master (
    output in_valid,
    output in_data,
    output en_mask,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  sel,
    input  grant,
    input  disp_cnt
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  en_mask,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output sel,
    output grant,
    output disp_cnt
  );

endinterface

// File: rtl/demux_rr_dispatcher_rr_arbiter_4.sv
// Combinational 4-way round-robin picker.
// Scans ptr, ptr+1, ... and grants the first eligible.
module rr_arbiter_4
  import demux_pkg::*;
(
  input  logic [N_CH-1:0] elig,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_any
);

  logic [CH_W-1:0] cand;

  // Walk offsets high to low so the nearest one to ptr wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = ptr + CH_W'(k);
      if (elig[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Round-robin 1-to-4 dispatcher with one-entry
// registered output per channel and per-channel back-pressure.
module demux_rr_dispatcher
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input logic clk,
  input logic rst,
  demux_rr_dispatcher_if.slave bus
);

  logic [N_CH-1:0]             free;
  logic [N_CH-1:0]             elig;
  logic [CH_W-1:0]             gnt_idx;
  logic                        gnt_any;
  logic                        xfer;
  logic [N_CH-1:0]             vld_q;
  logic [N_CH-1:0][DATA_W-1:0] dat_q;
  ctl_t                        ctl_q;
  ctl_t                        ctl_d;

  assign free = ~vld_q | bus.out_ready;
  assign elig = bus.en_mask & free;

  rr_arbiter_4 u_arb (
    .elig    (elig),
    .ptr     (ctl_q.ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign bus.in_ready = gnt_any;
  assign xfer         = bus.in_valid & gnt_any;

  // Next control state: move pointer past the winner on a transfer.
  always_comb begin
    ctl_d       = ctl_q;
    ctl_d.grant = xfer;
    if (xfer) begin
      ctl_d.ptr = rr_next(gnt_idx);
      ctl_d.sel = gnt_idx;
      ctl_d.cnt = ctl_q.cnt + 8'd1;
    end
  end

  // Control register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q <= '0;
    end else begin
      ctl_q <= ctl_d;
    end
  end

  // Channel registers: reload beats drain on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (xfer && gnt_idx == CH_W'(i)) begin
          vld_q[i] <= 1'b1;
          dat_q[i] <= bus.in_data;
        end else if (bus.out_ready[i]) begin
          vld_q[i] <= 1'b0;
        end
      end
    end
  end

  // Flatten channel data onto the output bus.
  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      bus.out_data[ch_slice(i, DATA_W) +: DATA_W] = dat_q[i];
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.sel       = ctl_q.sel;
  assign bus.grant     = ctl_q.grant;
  assign bus.disp_cnt  = ctl_q.cnt;

endmodule
